seq_shift_norm: RTL and testbench

//  Multi-cycle, parametrised mantissa shifter for the FP datapath. Shifts one bit per

---
 rtl/seq_shift_norm_pkg.sv | 30 +++
 rtl/seq_shift_norm_shift_step.sv | 34 +++
 rtl/seq_shift_norm.sv | 129 ++++++++++++
 tb/tb_seq_shift_norm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_norm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_shift_pkg : shared types for the multi-cycle mantissa shifter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fp_shift_pkg;

  localparam int SHN_W = 25;

  typedef enum logic [1:0] {
    SH_LEFT  = 2'd0,
    SH_PASS  = 2'd1,
    SH_RIGHT = 2'd2,
    SH_NORM  = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_HOLD  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/seq_shift_norm_shift_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_step : single-position left/right/hold shift of W bits     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module shift_step
  import fp_shift_pkg::*;
#(
  parameter int W = SHN_W
) (
  input  logic [W-1:0] din,
  input  dir_t         dir,
  output logic [W-1:0] dout,
  output logic         bit_out
);

  always_comb begin
    dout    = din;
    bit_out = 1'b0;
    case (dir)
      DIR_LEFT: begin
        dout    = {din[W-2:0], 1'b0};
        bit_out = din[W-1];
      end
      DIR_RIGHT: begin
        dout    = {1'b0, din[W-1:1]};
        bit_out = din[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_shift_norm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_shift_norm : one-bit-per-cycle shifter / normaliser with     |
// | valid/ready handshakes on both sides.  Rev 1.0                   |
// +------------------------------------------------------------------+
module seq_shift_norm
  import fp_shift_pkg::*;
#(
  parameter int W  = SHN_W,
  parameter int AW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_op,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_count,
  output logic          out_sticky,
  output logic          out_zero
);

  localparam logic [AW-1:0] c_w_amt = AW'(W);

  // Leading-zero count; the highest set bit wins, zero input yields 0.
  function automatic logic [AW-1:0] f_lzc(input logic [W-1:0] d);
    logic [AW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      if (d[i]) n = AW'(W - 1 - i);
    end
    return n;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_data;
  logic [AW-1:0] r_count;
  logic [AW-1:0] r_rem;
  logic          r_sticky;
  dir_t          r_dir;

  shift_op_t     w_op;
  logic [AW-1:0] w_amt;
  logic [AW-1:0] w_k;
  dir_t          w_dir;
  dir_t          w_step_dir;
  logic [W-1:0]  w_step_data;
  logic          w_step_bit;

  // Shift count is resolved up front so NORM runs the same countdown as SHL.
  always_comb begin
    w_op  = shift_op_t'(in_op);
    w_amt = (in_amt > c_w_amt) ? c_w_amt : in_amt;
    w_k   = '0;
    w_dir = DIR_HOLD;
    case (w_op)
      SH_LEFT:  begin w_k = w_amt;          w_dir = DIR_LEFT;  end
      SH_RIGHT: begin w_k = w_amt;          w_dir = DIR_RIGHT; end
      SH_NORM:  begin w_k = f_lzc(in_data); w_dir = DIR_LEFT;  end
      default:  ;
    endcase
  end

  assign w_step_dir = (r_state == ST_SHIFT) ? r_dir : DIR_HOLD;

  shift_step #(.W(W)) u_step (
    .din     (r_data),
    .dir     (w_step_dir),
    .dout    (w_step_data),
    .bit_out (w_step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = (w_k == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_rem == AW'(1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_count  <= '0;
      r_rem    <= '0;
      r_sticky <= 1'b0;
      r_dir    <= DIR_HOLD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data   <= in_data;
            r_count  <= '0;
            r_rem    <= w_k;
            r_sticky <= 1'b0;
            r_dir    <= w_dir;
          end
        end
        ST_SHIFT: begin
          r_data  <= w_step_data;
          r_count <= r_count + AW'(1);
          r_rem   <= r_rem - AW'(1);
          if (r_dir == DIR_RIGHT) r_sticky <= r_sticky | w_step_bit;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_data   = r_data;
  assign out_count  = r_count;
  assign out_sticky = r_sticky;
  assign out_zero   = out_valid & ~(|r_data);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_norm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_shift_norm : directed self-checking bench for the shifter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_seq_shift_norm;

  localparam int W  = 25;
  localparam int AW = 5;
  localparam longint MASK = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_op = '0;
  logic [AW-1:0] in_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_count;
  logic          out_sticky;
  logic          out_zero;

  int tests = 0;
  int fails = 0;

  // Expectation shared with the per-cycle compare process
  bit     armed = 1'b0;
  longint e_data;
  int     e_cnt;
  bit     e_st;
  int     e_lat;

  seq_shift_norm #(.W(W), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .in_amt     (in_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_sticky (out_sticky),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what the result must be, from plain arithmetic on the operand.
  task automatic model(input int op, input longint a, input int amt,
                       output longint d, output int cnt, output bit st, output int lat);
    int k;
    k  = 0;
    st = 1'b0;
    d  = a;
    case (op)
      0: begin k = (amt > W) ? W : amt; d = (a << k) & MASK; end
      2: begin
        k  = (amt > W) ? W : amt;
        d  = a >> k;
        st = (a % (64'd1 << k)) != 0;
      end
      3: begin
        if (a != 0) while ((a << k) < (64'd1 << (W - 1))) k++;
        d = (a << k) & MASK;
      end
      default: k = 0;
    endcase
    cnt = k;
    lat = (k == 0) ? 1 : k + 1;
  endtask

  always @(negedge clk) begin
    if (!reset && armed && out_valid) begin
      chk("data",     longint'(out_data),   e_data);
      chk("count",    longint'(out_count),  longint'(e_cnt));
      chk("sticky",   longint'(out_sticky), longint'(e_st));
      chk("zero",     longint'(out_zero),   longint'(e_data == 0));
      chk("in_ready_done", longint'(in_ready), 0);
    end
  end

  task automatic do_req(input int op, input longint a, input int amt, input int hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    chk("ready_before_req", longint'(in_ready), 1);
    model(op, a, amt, e_data, e_cnt, e_st, e_lat);
    armed    = 1'b1;
    in_valid = 1'b1;
    in_op    = op[1:0];
    in_data  = a[W-1:0];
    in_amt   = amt[AW-1:0];
    @(posedge clk); n = 1; #1;
    in_valid = 1'b0;
    in_data  = '1;
    in_amt   = '1;
    while (!out_valid && n < 60) begin @(posedge clk); n++; #1; end
    chk("latency", longint'(n), longint'(e_lat));
    // Hold the consumer off; a stray request meanwhile must be ignored.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'd1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", longint'(out_valid), 0);
    chk("ready_after_hs", longint'(in_ready), 1);
    in_valid = 1'b0;
    armed    = 1'b0;
  endtask

  initial begin
    longint d;
    int     c, l;
    bit     s;

    // Pin the model against hand-derived results
    model(0, 25'h0000001, 4, d, c, s, l);
    chk("model_shl_data", d, 25'h0000010);
    chk("model_shl_lat", longint'(l), 5);
    model(2, 25'h0000013, 2, d, c, s, l);
    chk("model_shr_sticky", longint'(s), 1);
    chk("model_shr_data", d, 25'h0000004);
    model(3, 25'h0000800, 0, d, c, s, l);
    chk("model_norm_data", d, 25'h1000000);
    chk("model_norm_cnt", longint'(c), 13);
    model(0, 25'h1ABCDEF, 30, d, c, s, l);
    chk("model_clamp_cnt", longint'(c), 25);

    #1;
    chk("rst_in_ready",  longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data",  longint'(out_data), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_sticky",    longint'(out_sticky), 0);
    chk("rst_zero",      longint'(out_zero), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_req(0, 25'h0000001, 4, 0);
    do_req(2, 25'h0000013, 2, 0);
    do_req(3, 25'h0000800, 0, 0);
    do_req(3, 25'h0000000, 7, 0);
    do_req(1, 25'h1ABCDEF, 9, 0);
    do_req(3, 25'h1ABCDEF, 0, 0);
    do_req(0, 25'h1ABCDEF, 30, 3);
    do_req(2, 25'h1FFFFFF, 31, 1);
    do_req(2, 25'h0000010, 4, 0);
    do_req(2, 25'h00000FF, 0, 0);
    do_req(0, 25'h0F0F0F0, 25, 0);

    // Abort an in-flight SHR with an asynchronous reset pulse
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd2;
    in_data  = 25'h1234567;
    in_amt   = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_out_data",  longint'(out_data), 0);
    chk("abort_out_count", longint'(out_count), 0);
    chk("abort_sticky",    longint'(out_sticky), 0);
    chk("abort_zero",      longint'(out_zero), 0);
    chk("abort_in_ready",  longint'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_in_ready", longint'(in_ready), 1);
    do_req(2, 25'h1234567, 10, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
